pipe_ctrl: RTL and testbench

- Parametrised pipeline control block for the MIPS core; the next generation of the core's ad-hoc bbl/stop handling and exported hazard addresses.
- Tracks in-flight register writes in a scoreboard and detects read-after-write hazards at decode.
- Combines per-stage stall requests, external hold and redirect into per-stage stall/bubble vectors that drive pc_reg and every pipeline register.

---
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/bubble control with register-write scoreboard (optional PIPE_CTRL_PERF_EN counters)
module pipe_ctrl #(
    parameter int STAGES     = 5,
    parameter int ID_STAGE   = 1,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ext_hold,
    input  logic [STAGES-1:0]     i_stall_req,
    input  logic                  i_redirect,
    input  logic                  i_id_valid,
    input  logic                  i_id_read1,
    input  logic                  i_id_read2,
    input  logic [REG_ADDR_W-1:0] i_id_addr1,
    input  logic [REG_ADDR_W-1:0] i_id_addr2,
    input  logic                  i_id_wreg,
    input  logic [REG_ADDR_W-1:0] i_id_waddr,
    input  logic                  i_wb_wreg,
    input  logic [REG_ADDR_W-1:0] i_wb_waddr,
    output logic [STAGES-1:0]     o_stall,
    output logic [STAGES-1:0]     o_bubble,
    output logic                  o_issue,
    output logic                  o_hazard,
    output logic                  o_sb_err,
    output logic [31:0]           o_perf_stall_cnt,
    output logic [31:0]           o_perf_hazard_cnt
);
    localparam int NREG = 2 ** REG_ADDR_W;

    logic [CNT_W-1:0]  r_cnt [NREG];
    logic              r_sb_err;
    logic [STAGES-1:0] w_req;
    logic [STAGES-1:0] w_raw_stall;
    logic [STAGES-1:0] w_raw_bubble;
    logic              w_acc;
    logic              w_hazard;
    logic              w_issue;
    logic              w_inc;
    logic              w_dec;

    always_comb begin
        w_hazard = i_id_valid & (
              (i_id_read1 & (i_id_addr1 != '0) & (r_cnt[i_id_addr1] != '0))
            | (i_id_read2 & (i_id_addr2 != '0) & (r_cnt[i_id_addr2] != '0))
            | (i_id_wreg  & (i_id_waddr != '0) & (r_cnt[i_id_waddr] == '1)));
    end

    // Stall every register at or below the oldest requesting stage; bubble the one just above it.
    always_comb begin
        w_req               = i_stall_req;
        w_req[ID_STAGE]     = i_stall_req[ID_STAGE] | w_hazard;
        w_acc               = 1'b0;
        w_raw_stall         = '0;
        w_raw_bubble        = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            w_acc          = w_acc | w_req[j];
            w_raw_stall[j] = w_acc;
        end
        for (int j = 1; j < STAGES; j++) begin
            w_raw_bubble[j] = w_raw_stall[j-1] & ~w_raw_stall[j];
        end
        if (i_redirect && !w_raw_stall[ID_STAGE]) begin
            w_raw_bubble[ID_STAGE] = 1'b1;
        end
    end

    always_comb begin
        o_stall  = w_raw_stall;
        o_bubble = w_raw_bubble;
        if (i_rst) begin
            o_stall  = '0;
            o_bubble = '1;
        end else if (i_ext_hold) begin
            o_stall  = '1;
            o_bubble = '0;
        end
    end

    assign w_issue  = i_id_valid & ~w_raw_stall[ID_STAGE] & ~i_ext_hold & ~i_rst;
    assign o_issue  = w_issue;
    assign o_hazard = w_hazard;
    assign o_sb_err = r_sb_err;
    assign w_inc    = w_issue & i_id_wreg & (i_id_waddr != '0);
    assign w_dec    = i_wb_wreg & (i_wb_waddr != '0);

    // A decrement at zero is a bookkeeping error; the count is clamped rather than wrapped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sb_err <= 1'b0;
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_inc && w_dec && i_id_waddr == REG_ADDR_W'(i) && i_wb_waddr == REG_ADDR_W'(i)) begin
                    r_cnt[i] <= r_cnt[i];
                end else if (w_inc && i_id_waddr == REG_ADDR_W'(i)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec && i_wb_waddr == REG_ADDR_W'(i) && r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
            if (w_dec && r_cnt[i_wb_waddr] == '0) r_sb_err <= 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_hazard_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_stall_cnt  <= '0;
            r_perf_hazard_cnt <= '0;
        end else begin
            if (o_stall[0] && !i_ext_hold && r_perf_stall_cnt != '1)
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            if (w_hazard && r_perf_hazard_cnt != '1)
                r_perf_hazard_cnt <= r_perf_hazard_cnt + 32'd1;
        end
    end

    assign o_perf_stall_cnt  = r_perf_stall_cnt;
    assign o_perf_hazard_cnt = r_perf_hazard_cnt;
`else
    assign o_perf_stall_cnt  = '0;
    assign o_perf_hazard_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic       clk;
    logic       rst;
    logic       ext_hold;
    logic [4:0] stall_req;
    logic       redirect;
    logic       id_valid, id_read1, id_read2, id_wreg, wb_wreg;
    logic [4:0] id_addr1, id_addr2, id_waddr, wb_waddr;
    logic [4:0] stall, bubble;
    logic       issue, hazard, sb_err;
    logic [31:0] perf_stall_cnt, perf_hazard_cnt;

    int vectors = 0;
    int miscompares = 0;

    pipe_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_ext_hold(ext_hold), .i_stall_req(stall_req),
        .i_redirect(redirect), .i_id_valid(id_valid), .i_id_read1(id_read1),
        .i_id_read2(id_read2), .i_id_addr1(id_addr1), .i_id_addr2(id_addr2),
        .i_id_wreg(id_wreg), .i_id_waddr(id_waddr), .i_wb_wreg(wb_wreg),
        .i_wb_waddr(wb_waddr), .o_stall(stall), .o_bubble(bubble), .o_issue(issue),
        .o_hazard(hazard), .o_sb_err(sb_err), .o_perf_stall_cnt(perf_stall_cnt),
        .o_perf_hazard_cnt(perf_hazard_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ctl(input string tag, input logic [4:0] st, input logic [4:0] bb,
                              input logic is, input logic hz);
        #1;
        check_eq({tag, ".stall"}, 32'(stall), 32'(st));
        check_eq({tag, ".bubble"}, 32'(bubble), 32'(bb));
        check_eq({tag, ".issue"}, 32'(issue), 32'(is));
        check_eq({tag, ".hazard"}, 32'(hazard), 32'(hz));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ext_hold = 0; stall_req = 0; redirect = 0;
        id_valid = 0; id_read1 = 0; id_read2 = 0; id_wreg = 0; wb_wreg = 0;
        id_addr1 = 0; id_addr2 = 0; id_waddr = 0; wb_waddr = 0;
    endtask

    task automatic id_write(input logic [4:0] a);
        idle(); id_valid = 1; id_wreg = 1; id_waddr = a;
    endtask

    task automatic id_read(input logic [4:0] a);
        idle(); id_valid = 1; id_read1 = 1; id_addr1 = a;
    endtask

    initial begin
        idle();
        rst = 1;
        #2;
        expect_ctl("reset", 5'b00000, 5'b11111, 0, 0);
        cyc(); cyc();
        check_eq("reset.sb_err", 32'(sb_err), 0);
        rst = 0;

        // RAW on r5 until write-back
        id_write(5);
        expect_ctl("w5", 5'b00000, 5'b00000, 1, 0);
        cyc();
        id_read(5);
        expect_ctl("raw5.c1", 5'b00011, 5'b00100, 0, 1);
        cyc();
        expect_ctl("raw5.c2", 5'b00011, 5'b00100, 0, 1);
        cyc();
        wb_wreg = 1; wb_waddr = 5;
        expect_ctl("raw5.wb", 5'b00011, 5'b00100, 0, 1);
        cyc();
        wb_wreg = 0;
        expect_ctl("raw5.go", 5'b00000, 5'b00000, 1, 0);
`ifdef PIPE_CTRL_PERF_EN
        check_eq("perf.hazard", perf_hazard_cnt, 3);
        check_eq("perf.stall", perf_stall_cnt, 3);
`else
        check_eq("perf.hazard", perf_hazard_cnt, 0);
        check_eq("perf.stall", perf_stall_cnt, 0);
`endif
        cyc();

        // EX busy for three cycles
        idle(); id_valid = 1; stall_req = 5'b01000;
        for (int k = 0; k < 3; k++) begin
            expect_ctl($sformatf("exbusy.%0d", k), 5'b01111, 5'b10000, 0, 0);
            cyc();
        end
        stall_req = 0;
        expect_ctl("exbusy.end", 5'b00000, 5'b00000, 1, 0);
        cyc();

        // ext_hold over a hazard, write-back still retires
        id_write(5);
        cyc();
        id_read(5); ext_hold = 1; wb_wreg = 1; wb_waddr = 5;
        expect_ctl("hold", 5'b11111, 5'b00000, 0, 1);
        cyc();
        id_read(5);
        expect_ctl("hold.after", 5'b00000, 5'b00000, 1, 0);
        cyc();

        // redirect with and without a stall
        idle(); id_valid = 1; redirect = 1;
        expect_ctl("redir", 5'b00000, 5'b00010, 1, 0);
        cyc();
        id_write(6);
        cyc();
        id_read(6); redirect = 1;
        expect_ctl("redir.haz", 5'b00011, 5'b00100, 0, 1);
        wb_wreg = 1; wb_waddr = 6;
        cyc();
        idle();

        // scoreboard saturation on r7
        for (int k = 0; k < 3; k++) begin
            id_write(7);
            expect_ctl($sformatf("w7.%0d", k), 5'b00000, 5'b00000, 1, 0);
            cyc();
        end
        id_write(7);
        expect_ctl("w7.full", 5'b00011, 5'b00100, 0, 1);
        cyc();

        // write-back to an idle register
        idle(); wb_wreg = 1; wb_waddr = 9;
        #1 check_eq("sberr.pre", 32'(sb_err), 0);
        cyc();
        idle();
        check_eq("sberr.set", 32'(sb_err), 1);
        cyc();
        check_eq("sberr.hold", 32'(sb_err), 1);

        // r0 is never tracked
        idle(); id_valid = 1; id_read1 = 1; id_read2 = 1; id_wreg = 1;
        expect_ctl("r0", 5'b00000, 5'b00000, 1, 0);
        cyc();

        // reset with r7 still at 3
        idle(); rst = 1; id_valid = 1;
        expect_ctl("rst.mid", 5'b00000, 5'b11111, 0, 0);
        cyc();
        rst = 0;
        check_eq("rst.sb_err", 32'(sb_err), 0);
        id_read(7);
        expect_ctl("rst.r7", 5'b00000, 5'b00000, 1, 0);
        id_write(7);
        expect_ctl("rst.w7", 5'b00000, 5'b00000, 1, 0);
        cyc();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
